// File: rtl/fifo_ctrl_if.sv
// Handshake/status bundle between a FIFO front-end and its pointer/flag controller.
interface fifo_ctrl_if #(
  parameter int MAIN_QUEUE_SIZE = 3,
  parameter int UMBRAL_W        = 3
);
  logic                       push;
  logic                       pop;
  logic [UMBRAL_W-1:0]        umbral_alto;
  logic [UMBRAL_W-1:0]        umbral_bajo;
  logic                       write;
  logic                       read;
  logic [MAIN_QUEUE_SIZE-1:0] wr_ptr;
  logic [MAIN_QUEUE_SIZE-1:0] rd_ptr;
  logic [MAIN_QUEUE_SIZE-1:0] fifo_count;
  logic                       full;
  logic                       empty;
  logic                       almost_full;
  logic                       almost_empty;
  logic                       valid_out;
  logic                       overflow;
  logic                       underflow;

  modport master (
    output push, pop, umbral_alto, umbral_bajo,
    input  write, read, wr_ptr, rd_ptr, fifo_count,
    input  full, empty, almost_full, almost_empty,
    input  valid_out, overflow, underflow
  );

  modport slave (
    input  push, pop, umbral_alto, umbral_bajo,
    output write, read, wr_ptr, rd_ptr, fifo_count,
    output full, empty, almost_full, almost_empty,
    output valid_out, overflow, underflow
  );
endinterface

// File: rtl/fifo_ctrl.sv
// Pointer/occupancy/flag controller for a zero-filling FIFO RAM buffer.
// FIFO_ERR_FLAGS_EN builds sticky overflow/underflow flags.
module fifo_ctrl #(
  parameter int MAIN_QUEUE_SIZE = 3,
  parameter int UMBRAL_W        = 3
) (
  input  logic        clk,
  input  logic        reset_L,
  fifo_ctrl_if.slave  bus
);
  localparam int AW = MAIN_QUEUE_SIZE;
  localparam int CW = (UMBRAL_W > AW) ? UMBRAL_W : AW;
  // One slot stays free: the RAM zero-fills the slot at wr_ptr when idle.
  localparam logic [AW-1:0] FULL_CNT = '1;

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic          valid_q, valid_d;
  logic          full, empty;
  logic          pop_ok, push_ok;

  always_comb begin
    empty   = (cnt_q == '0);
    full    = (cnt_q == FULL_CNT);
    pop_ok  = bus.pop & ~empty;
    push_ok = bus.push & (~full | pop_ok);
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop_ok);
    cnt_d    = cnt_q + AW'(push_ok) - AW'(pop_ok);
    valid_d  = pop_ok;
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      valid_q  <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      valid_q  <= valid_d;
    end
  end

`ifdef FIFO_ERR_FLAGS_EN
  logic ovf_q, ovf_d;
  logic unf_q, unf_d;

  always_comb begin
    ovf_d = ovf_q | (bus.push & full & ~pop_ok);
    unf_d = unf_q | (bus.pop & empty);
  end

  always_ff @(posedge clk or negedge reset_L) begin
    if (!reset_L) begin
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  assign bus.overflow  = ovf_q;
  assign bus.underflow = unf_q;
`else
  assign bus.overflow  = 1'b0;
  assign bus.underflow = 1'b0;
`endif

  assign bus.write        = push_ok;
  assign bus.read         = pop_ok;
  assign bus.wr_ptr       = wr_ptr_q;
  assign bus.rd_ptr       = rd_ptr_q;
  assign bus.fifo_count   = cnt_q;
  assign bus.full         = full;
  assign bus.empty        = empty;
  assign bus.almost_full  = CW'(cnt_q) >= CW'(bus.umbral_alto);
  assign bus.almost_empty = CW'(cnt_q) <= CW'(bus.umbral_bajo);
  assign bus.valid_out    = valid_q;
endmodule

// File: tb/tb_fifo_ctrl.sv
// Randomized check of fifo_ctrl against a queue model plus a zero-filling RAM.
// Covers fill/drain, wrap, full/empty corners, thresholds and async reset.
module tb_fifo_ctrl;
  localparam int D = 8;
`ifdef FIFO_ERR_FLAGS_EN
  localparam bit ERR_EN = 1'b1;
`else
  localparam bit ERR_EN = 1'b0;
`endif

  logic clk;
  logic reset_L;
  logic [7:0] wdata;
  logic [7:0] dout;
  logic [7:0] mem [D];

  fifo_ctrl_if #(.MAIN_QUEUE_SIZE(3), .UMBRAL_W(3)) bus ();

  fifo_ctrl #(.MAIN_QUEUE_SIZE(3), .UMBRAL_W(3)) dut (
    .clk     (clk),
    .reset_L (reset_L),
    .bus     (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (bus.write) mem[bus.wr_ptr] <= wdata;
    else           mem[bus.wr_ptr] <= '0;
    dout <= bus.read ? mem[bus.rd_ptr] : '0;
  end

  int n_chk;
  int n_bad;
  logic [7:0] q [$];
  int  pushes, pops;
  bit  v_m;
  logic [7:0] exp_data;
  bit  ovf_m, unf_m;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    pushes = 0;
    pops   = 0;
    v_m    = 1'b0;
    ovf_m  = 1'b0;
    unf_m  = 1'b0;
  endtask

  task automatic check_all();
    int cnt;
    bit full_m, empty_m, pop_ok, push_ok;
    cnt     = q.size();
    full_m  = (cnt == D - 1);
    empty_m = (cnt == 0);
    pop_ok  = bus.pop && !empty_m;
    push_ok = bus.push && (!full_m || pop_ok);
    chk("write",  bus.write,  push_ok);
    chk("read",   bus.read,   pop_ok);
    chk("wr_ptr", bus.wr_ptr, pushes % D);
    chk("rd_ptr", bus.rd_ptr, pops % D);
    chk("count",  bus.fifo_count, cnt);
    chk("full",   bus.full,   full_m);
    chk("empty",  bus.empty,  empty_m);
    chk("afull",  bus.almost_full,  cnt >= int'(bus.umbral_alto));
    chk("aempty", bus.almost_empty, cnt <= int'(bus.umbral_bajo));
    chk("valid",  bus.valid_out, v_m);
    chk("ovf",    bus.overflow,  ERR_EN & ovf_m);
    chk("unf",    bus.underflow, ERR_EN & unf_m);
    if (v_m) chk("data", dout, exp_data);
  endtask

  task automatic model_edge();
    int cnt;
    bit pop_ok, push_ok;
    cnt     = q.size();
    pop_ok  = bus.pop && cnt != 0;
    push_ok = bus.push && (cnt != D - 1 || pop_ok);
    if (bus.push && cnt == D - 1 && !pop_ok) ovf_m = 1'b1;
    if (bus.pop && cnt == 0) unf_m = 1'b1;
    if (pop_ok) begin
      exp_data = q.pop_front();
      pops++;
    end
    if (push_ok) begin
      q.push_back(wdata);
      pushes++;
    end
    v_m = pop_ok;
  endtask

  task automatic step(input logic p, input logic r,
                      input logic [2:0] ua, input logic [2:0] ub);
    @(negedge clk);
    bus.push        = p;
    bus.pop         = r;
    bus.umbral_alto = ua;
    bus.umbral_bajo = ub;
    wdata           = 8'($urandom);
    #1;
    check_all();
    model_edge();
  endtask

  initial begin
    n_chk = 0;
    n_bad = 0;
    model_reset();
    exp_data        = '0;
    reset_L         = 1'b0;
    bus.push        = 1'b0;
    bus.pop         = 1'b0;
    bus.umbral_alto = 3'd0;
    bus.umbral_bajo = 3'd0;
    wdata           = '0;
    #3;
    check_all();
    @(negedge clk);
    reset_L = 1'b1;

    // fill past capacity, then drain past empty
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 3'd5, 3'd2);
    step(1'b1, 1'b1, 3'd5, 3'd2);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 3'd5, 3'd2);
    step(1'b1, 1'b1, 3'd5, 3'd2);
    step(1'b0, 1'b1, 3'd5, 3'd2);

    // push 10, each popped the cycle after
    step(1'b1, 1'b0, 3'd4, 3'd1);
    for (int i = 0; i < 9; i++) step(1'b1, 1'b1, 3'd4, 3'd1);
    step(1'b0, 1'b1, 3'd4, 3'd1);
    step(1'b0, 1'b0, 3'd4, 3'd1);

    // randomized traffic with moving thresholds
    for (int i = 0; i < 400; i++) begin
      int bias;
      bias = ((i / 40) % 2 == 0) ? 75 : 25;
      step($urandom_range(0, 99) < bias, $urandom_range(0, 99) >= bias - 10,
           3'($urandom), 3'($urandom));
    end

    // async reset with count=4 and a pop in flight
    while (q.size() > 5) step(1'b0, 1'b1, 3'd5, 3'd2);
    while (q.size() < 5) step(1'b1, 1'b0, 3'd5, 3'd2);
    step(1'b0, 1'b1, 3'd5, 3'd2);
    @(negedge clk);
    bus.push = 1'b0;
    bus.pop  = 1'b0;
    #1;
    check_all();
    #1;
    reset_L = 1'b0;
    model_reset();
    #1;
    check_all();
    @(negedge clk);
    reset_L = 1'b1;
    for (int i = 0; i < 6; i++) step(1'b1, i[0], 3'd3, 3'd3);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

// File: doc/fifo_ctrl.md
Name: fifo_ctrl

Overview:
- Pointer and flag controller for the single-port-per-direction RAM buffer used in the FIFO datapath.
- Accepts push/pop requests and drives the RAM's write, read, wr_ptr and rd_ptr.
- Tracks occupancy and produces full, empty, almost_full, almost_empty and a valid strobe aligned to the RAM's registered data_out.
- One instance sits beside each RAM buffer, inside every FIFO of the design.

Parameters:
- MAIN_QUEUE_SIZE, 3: pointer width. RAM depth D = 2**MAIN_QUEUE_SIZE.
- UMBRAL_W, 3: width of the threshold inputs. Must equal MAIN_QUEUE_SIZE.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset_L  in  1  asynchronous, active-low reset.
- push  in  1  write request for this cycle.
- pop  in  1  read request for this cycle.
- umbral_alto  in  UMBRAL_W  almost-full threshold.
- umbral_bajo  in  UMBRAL_W  almost-empty threshold.
- write  out  1  RAM write enable (combinational).
- read  out  1  RAM read enable (combinational).
- wr_ptr  out  MAIN_QUEUE_SIZE  RAM write address (registered).
- rd_ptr  out  MAIN_QUEUE_SIZE  RAM read address (registered).
- fifo_count  out  MAIN_QUEUE_SIZE  current occupancy.
- full  out  1  fifo_count == D-1.
- empty  out  1  fifo_count == 0.
- almost_full  out  1  fifo_count >= umbral_alto.
- almost_empty  out  1  fifo_count <= umbral_bajo.
- valid_out  out  1  RAM data_out holds a popped word this cycle.
- overflow  out  1  sticky push-while-full error (optional feature).
- underflow  out  1  sticky pop-while-empty error (optional feature).

Behaviour:
- Reset (reset_L low, asynchronous):
  - wr_ptr, rd_ptr, fifo_count, valid_out, overflow, underflow = 0.
  - Resulting flags: empty=1, full=0, almost_empty=1, almost_full = (umbral_alto==0).
- Capacity:
  - Capacity is D-1 entries, not D.
  - The RAM zero-fills the slot at wr_ptr on every clock where write is low. The slot at wr_ptr must therefore never hold live data; reserving one slot guarantees this.
- Acceptance (combinational):
  - pop_ok = pop & ~empty.
  - push_ok = push & (~full | pop_ok).
  - write = push_ok; read = pop_ok.
- Register updates on clk rising edge:
  - wr_ptr += push_ok; rd_ptr += pop_ok. Both wrap modulo D.
  - fifo_count += push_ok - pop_ok (no wrap; range 0..D-1).
- Read latency: 1 cycle. valid_out <= pop_ok, so valid_out is high in the cycle the RAM's data_out presents the word.
  - While valid_out is low, RAM data_out is 0 and must be ignored downstream.
- Flags: all four are combinational decodes of fifo_count and the thresholds. They change in the cycle after the accepting edge.
- Boundary conditions:
  - Full with push and pop: both accepted, count stays D-1, pointers both advance.
  - Full with push only: push dropped, no state change.
  - Empty with push and pop: only the push is accepted. No read-through; valid_out stays 0 next cycle.
  - Empty with pop only: ignored, read=0.
  - Pointer wrap D-1 -> 0 requires no special handling.
- Threshold inputs may change at any time; flags follow in the same cycle.
- Reset asserted mid-operation: all state clears immediately. An in-flight valid_out is dropped.

Optional Feature:
- Macro: FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow sets on the edge where push & full & ~pop_ok.
  - underflow sets on the edge where pop & empty.
  - Both are sticky until reset_L is asserted.
- Undefined:
  - overflow and underflow ports remain present and are tied to 0.
  - No error-flag registers are built.

Test Plan (MAIN_QUEUE_SIZE=3, D=8, capacity 7):
- Reset, then 7 consecutive pushes -> wr_ptr=7, fifo_count=7, full=1, empty=0. An 8th push gives write=0 and wr_ptr stays 7; overflow=1 if FIFO_ERR_FLAGS_EN is defined.
- From full, 7 pops -> read=1 on each; valid_out=1 one cycle after each pop; rd_ptr=7, empty=1. A further pop gives read=0; underflow=1 if the macro is defined.
- Wrap-around: push 10 words while popping each one the cycle after its push -> pointers wrap 7->0, fifo_count never exceeds 1, data is returned in order.
- Full plus simultaneous push and pop -> write=1, read=1, count stays 7, full stays 1. Empty plus simultaneous push and pop -> write=1, read=0, count becomes 1.
- umbral_alto=5, umbral_bajo=2, count ramped 0->7 -> almost_empty=1 for counts 0..2, almost_full=1 for counts 5..7.
- Assert reset_L low while count=4 and a pop is in flight -> all outputs return to reset values immediately, with no clock edge needed.
